dm_port_arbiter: RTL and testbench

//  Shares the single-port data memory (dm) between the pipeline MEM stage and a

---
 rtl/dm_port_arbiter.sv | 109 ++++++++++
 tb/tb_dm_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: the MEM stage has priority over the DMA master,
// and a starvation counter forces one DMA grant (stalling the CPU) after a long wait.
module dm_port_arbiter #(
    parameter int AW           = 7,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic          dm_rd,
    output logic          dm_wr,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_wdata,
    input  logic [DW-1:0] dm_rdata
);

    typedef enum logic {
        S_NORM  = 1'b0,
        S_FORCE = 1'b1
    } state_t;

    localparam logic [7:0] LIMIT    = 8'(STARVE_LIMIT);
    localparam logic [7:0] LIMIT_M1 = 8'(STARVE_LIMIT - 1);

    state_t        state_reg, state_next;
    logic [7:0]    wait_cnt_reg, wait_cnt_next;
    logic          dma_rvalid_reg;
    logic [DW-1:0] dma_rdata_reg;
    logic          cpu_act;
    logic          force_win;
    logic          cpu_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_NORM;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // S_FORCE lasts one cycle, so a stalled CPU is always served right after.
    always_comb begin
        state_next    = S_NORM;
        wait_cnt_next = '0;
        if (dma_req && !dma_gnt) begin
            wait_cnt_next = (wait_cnt_reg >= LIMIT) ? LIMIT : wait_cnt_reg + 8'd1;
        end
        if (state_reg == S_NORM && dma_req && !dma_gnt && wait_cnt_reg == LIMIT_M1) begin
            state_next = S_FORCE;
        end
    end

    always_comb begin
        cpu_act   = cpu_rd | cpu_wr;
        force_win = (state_reg == S_FORCE) && dma_req;
        dma_gnt   = dma_req && (force_win || !cpu_act);
        cpu_gnt   = cpu_act && !dma_gnt;
        cpu_stall = cpu_act && dma_gnt;
        dm_rd     = 1'b0;
        dm_wr     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        if (dma_gnt) begin
            dm_rd    = !dma_we;
            dm_wr    = dma_we;
            dm_addr  = dma_addr;
            dm_wdata = dma_wdata;
        end else if (cpu_gnt) begin
            // A simultaneous rd+wr from the MEM stage is treated as a store.
            dm_rd    = !cpu_wr;
            dm_wr    = cpu_wr;
            dm_addr  = cpu_addr;
            dm_wdata = cpu_wdata;
        end
    end

    assign cpu_rdata = dm_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dma_rvalid_reg <= 1'b0;
            dma_rdata_reg  <= '0;
        end else if (dma_gnt && !dma_we) begin
            dma_rvalid_reg <= 1'b1;
            dma_rdata_reg  <= dm_rdata;
        end else begin
            dma_rvalid_reg <= 1'b0;
        end
    end

    assign dma_rvalid = dma_rvalid_reg;
    assign dma_rdata  = dma_rdata_reg;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: directed scenarios plus randomized traffic checked
// against a wait-counting reference model and a shadow copy of the data memory.
module tb_dm_port_arbiter;

    localparam int AW    = 7;
    localparam int DW    = 32;
    localparam int LIMIT = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_rd, cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_stall;
    logic          dma_req, dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_gnt, dma_rvalid;
    logic [DW-1:0] dma_rdata;
    logic          dm_rd, dm_wr;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata, dm_rdata;

    logic [DW-1:0] dm_mem [DEPTH];

    dm_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    // Data memory behind the arbiter: combinational read, write on the clock edge.
    assign dm_rdata = dm_mem[dm_addr];
    always @(posedge clk) begin
        if (dm_wr) dm_mem[dm_addr] <= dm_wdata;
    end

    // Reference model state
    int            waited;
    logic          exp_rvalid;
    logic [DW-1:0] exp_rdata;
    logic [DW-1:0] ref_mem [DEPTH];
    logic          e_dma_gnt, e_cpu_srv, e_stall, e_dm_rd, e_dm_wr;
    logic [AW-1:0] e_dm_addr;
    logic [DW-1:0] e_dm_wdata;

    int checks = 0;
    int passes = 0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic drive(input logic c_rd, c_wr, input logic [AW-1:0] c_a,
                         input logic [DW-1:0] c_d, input logic d_req, d_we,
                         input logic [AW-1:0] d_a, input logic [DW-1:0] d_d);
        cpu_rd = c_rd; cpu_wr = c_wr; cpu_addr = c_a; cpu_wdata = c_d;
        dma_req = d_req; dma_we = d_we; dma_addr = d_a; dma_wdata = d_d;
    endtask

    // The DMA is forced in once it has already waited LIMIT cycles in a row.
    task automatic predict();
        logic act, forced;
        act        = cpu_rd | cpu_wr;
        forced     = dma_req && (waited >= LIMIT);
        e_dma_gnt  = dma_req && (forced || !act);
        e_cpu_srv  = act && !e_dma_gnt;
        e_stall    = act && e_dma_gnt;
        e_dm_rd    = 1'b0; e_dm_wr = 1'b0; e_dm_addr = '0; e_dm_wdata = '0;
        if (e_dma_gnt) begin
            e_dm_rd = !dma_we; e_dm_wr = dma_we; e_dm_addr = dma_addr; e_dm_wdata = dma_wdata;
        end else if (e_cpu_srv) begin
            e_dm_rd = !cpu_wr; e_dm_wr = cpu_wr; e_dm_addr = cpu_addr; e_dm_wdata = cpu_wdata;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        exp_rvalid = 1'b0;
        if (e_dma_gnt) begin
            waited = 0;
            if (dma_we) ref_mem[dma_addr] = dma_wdata;
            else begin
                exp_rvalid = 1'b1;
                exp_rdata  = ref_mem[dma_addr];
            end
        end else begin
            waited = dma_req ? waited + 1 : 0;
        end
        if (e_cpu_srv && cpu_wr) ref_mem[cpu_addr] = cpu_wdata;
        #1;
    endtask

    task automatic idle_cycle();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        @(negedge clk);
        predict();
        advance();
    endtask

    task automatic model_reset();
        waited = 0; exp_rvalid = 1'b0; exp_rdata = '0;
    endtask

    task automatic test_reset();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (dma_rvalid !== 1'b0) $display("FAIL reset.rvalid: got %0b want 0", dma_rvalid); else passes++;
        checks++; if (dma_rdata !== '0) $display("FAIL reset.rdata: got %h want 0", dma_rdata); else passes++;
        checks++; if ({dma_gnt, cpu_stall, dm_rd, dm_wr} !== 4'b0) $display("FAIL reset.ctrl: got %b want 0000", {dma_gnt, cpu_stall, dm_rd, dm_wr}); else passes++;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int a = 0; a < DEPTH; a++) begin
            drive(0, 0, '0, '0, 1, 1, AW'(a), $urandom);
            @(negedge clk);
            predict();
            checks++; if ({dma_gnt, dm_wr, dm_addr} !== {2'b11, AW'(a)}) $display("FAIL fill.gnt: got %b/%b/%0d want 1/1/%0d", dma_gnt, dm_wr, dm_addr, a); else passes++;
            advance();
        end
        idle_cycle();
    endtask

    task automatic test_reset_in_force();
        drive(0, 0, '0, '0, 1, 1, 7'd20, 32'hDEADBEEF);
        @(negedge clk); predict(); advance();
        drive(0, 0, '0, '0, 1, 0, 7'd20, '0);
        @(negedge clk); predict(); advance();
        checks++; if (dma_rdata !== 32'hDEADBEEF) $display("FAIL rstf.pre_rdata: got %h want deadbeef", dma_rdata); else passes++;
        for (int c = 1; c <= LIMIT; c++) begin
            drive(1, 0, 7'd2, '0, 1, 0, 7'd20, '0);
            @(negedge clk); predict();
            checks++; if (dma_gnt !== 1'b0) $display("FAIL rstf.wait%0d: got gnt %0b want 0", c, dma_gnt); else passes++;
            advance();
        end
        @(negedge clk);
        checks++; if ({dma_gnt, cpu_stall} !== 2'b11) $display("FAIL rstf.force: got %b want 11", {dma_gnt, cpu_stall}); else passes++;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if ({dma_rvalid, dma_rdata} !== '0) $display("FAIL rstf.regs: got %0b/%h want 0/0", dma_rvalid, dma_rdata); else passes++;
        checks++; if ({dma_gnt, cpu_stall} !== 2'b00) $display("FAIL rstf.norm_in_rst: got %b want 00", {dma_gnt, cpu_stall}); else passes++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); predict();
        checks++; if ({dma_gnt, cpu_stall, dm_rd, dm_addr} !== {3'b001, 7'd2}) $display("FAIL rstf.after: got %b/%b/%b/%0d want 0/0/1/2", dma_gnt, cpu_stall, dm_rd, dm_addr); else passes++;
        advance();
        checks++; if (dma_rvalid !== 1'b0) $display("FAIL rstf.no_return: got %0b want 0", dma_rvalid); else passes++;
        drive(0, 0, '0, '0, 1, 0, 7'd20, '0);
        @(negedge clk); predict(); advance();
        idle_cycle();
    endtask

    task automatic test_dma_rw();
        drive(0, 0, '0, '0, 1, 1, 7'd5, 32'hA5);
        @(negedge clk); predict();
        checks++; if ({dma_gnt, dm_wr, dm_rd, dm_addr} !== {3'b110, 7'd5}) $display("FAIL dma_rw.wr: got %b%b%b/%0d want 110/5", dma_gnt, dm_wr, dm_rd, dm_addr); else passes++;
        advance();
        drive(0, 0, '0, '0, 1, 0, 7'd5, '0);
        @(negedge clk); predict();
        checks++; if ({dma_gnt, dm_rd} !== 2'b11) $display("FAIL dma_rw.rd: got %b want 11", {dma_gnt, dm_rd}); else passes++;
        advance();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        checks++; if ({dma_rvalid, dma_rdata} !== {1'b1, 32'hA5}) $display("FAIL dma_rw.ret: got %0b/%h want 1/a5", dma_rvalid, dma_rdata); else passes++;
        @(negedge clk); predict(); advance();
        checks++; if (dma_rvalid !== 1'b0) $display("FAIL dma_rw.pulse: got %0b want 0", dma_rvalid); else passes++;
    endtask

    task automatic test_cpu_priority();
        drive(1, 0, 7'd3, '0, 1, 0, 7'd9, '0);
        @(negedge clk); predict();
        checks++; if ({dm_rd, dm_addr, dma_gnt, cpu_stall} !== {1'b1, 7'd3, 2'b00}) $display("FAIL prio.cpu: got %b/%0d/%b/%b want 1/3/0/0", dm_rd, dm_addr, dma_gnt, cpu_stall); else passes++;
        checks++; if (cpu_rdata !== ref_mem[3]) $display("FAIL prio.rdata: got %h want %h", cpu_rdata, ref_mem[3]); else passes++;
        advance();
        checks++; if (dut.wait_cnt_reg !== 8'd1) $display("FAIL prio.wait_cnt: got %0d want 1", dut.wait_cnt_reg); else passes++;
        drive(0, 0, '0, '0, 1, 0, 7'd9, '0);
        @(negedge clk); predict(); advance();
        idle_cycle();
    endtask

    task automatic test_starvation();
        for (int c = 1; c <= LIMIT + 2; c++) begin
            drive(1, 0, 7'd4, '0, c <= LIMIT + 1, 1, 7'd30, 32'hC0DE0000 + c);
            @(negedge clk); predict();
            checks++; if (dma_gnt !== (c == LIMIT + 1)) $display("FAIL starve.gnt%0d: got %0b want %0b", c, dma_gnt, c == LIMIT + 1); else passes++;
            checks++; if (cpu_stall !== (c == LIMIT + 1)) $display("FAIL starve.stall%0d: got %0b want %0b", c, cpu_stall, c == LIMIT + 1); else passes++;
            if (c == LIMIT + 2) begin
                checks++; if ({dm_rd, dut.wait_cnt_reg} !== {1'b1, 8'd0}) $display("FAIL starve.after: got %0b/%0d want 1/0", dm_rd, dut.wait_cnt_reg); else passes++;
            end
            advance();
        end
        idle_cycle();
    endtask

    task automatic test_force_drop();
        for (int c = 1; c <= LIMIT; c++) begin
            drive(0, 1, 7'd11, 32'h55 + c, 1, 0, 7'd12, '0);
            @(negedge clk); predict(); advance();
        end
        drive(0, 1, 7'd11, 32'h77, 0, 0, 7'd12, '0);
        @(negedge clk); predict();
        checks++; if ({dma_gnt, cpu_stall, dm_wr, dm_addr} !== {3'b001, 7'd11}) $display("FAIL drop.cycle: got %b/%b/%b/%0d want 0/0/1/11", dma_gnt, cpu_stall, dm_wr, dm_addr); else passes++;
        advance();
        checks++; if (dut.wait_cnt_reg !== 8'd0) $display("FAIL drop.wait_cnt: got %0d want 0", dut.wait_cnt_reg); else passes++;
        drive(0, 1, 7'd11, 32'h78, 1, 0, 7'd12, '0);
        @(negedge clk); predict();
        checks++; if ({dma_gnt, cpu_stall} !== 2'b00) $display("FAIL drop.norm: got %b want 00", {dma_gnt, cpu_stall}); else passes++;
        advance();
        drive(0, 0, '0, '0, 1, 0, 7'd12, '0);
        @(negedge clk); predict(); advance();
        idle_cycle();
    endtask

    task automatic test_rw_both();
        drive(1, 1, 7'd7, 32'h1234, 0, 0, '0, '0);
        @(negedge clk); predict();
        checks++; if ({dm_wr, dm_rd, dm_wdata} !== {2'b10, 32'h1234}) $display("FAIL both.wr: got %b%b/%h want 10/1234", dm_wr, dm_rd, dm_wdata); else passes++;
        advance();
        idle_cycle();
        drive(1, 0, 7'd7, '0, 0, 0, '0, '0);
        @(negedge clk); predict();
        checks++; if (cpu_rdata !== 32'h1234) $display("FAIL both.rd: got %h want 1234", cpu_rdata); else passes++;
        advance();
        idle_cycle();
    endtask

    task automatic test_random();
        logic          hold_cpu = 1'b0, dma_pend = 1'b0;
        logic          r_rd = 0, r_wr = 0, r_req = 0, r_we = 0;
        logic [AW-1:0] r_ca = '0, r_da = '0;
        logic [DW-1:0] r_cd = '0, r_dd = '0;
        int            r;
        for (int n = 0; n < 400; n++) begin
            if (!hold_cpu) begin
                r    = int'($urandom_range(0, 99));
                r_rd = (r < 50);
                r_wr = (r >= 40 && r < 85);
                r_ca = AW'($urandom);
                r_cd = $urandom;
            end
            if (!dma_pend) begin
                r_req = ($urandom_range(0, 1) == 1);
                r_we  = ($urandom_range(0, 1) == 1);
                r_da  = AW'($urandom);
                r_dd  = $urandom;
            end
            drive(r_rd, r_wr, r_ca, r_cd, r_req, r_we, r_da, r_dd);
            @(negedge clk); predict();
            checks++; if (dma_gnt !== e_dma_gnt) $display("FAIL rnd%0d.gnt: got %0b want %0b", n, dma_gnt, e_dma_gnt); else passes++;
            checks++; if (cpu_stall !== e_stall) $display("FAIL rnd%0d.stall: got %0b want %0b", n, cpu_stall, e_stall); else passes++;
            checks++; if ({dm_rd, dm_wr, dm_addr, dm_wdata} !== {e_dm_rd, e_dm_wr, e_dm_addr, e_dm_wdata})
                $display("FAIL rnd%0d.dm: got %b%b/%0d/%h want %b%b/%0d/%h", n, dm_rd, dm_wr, dm_addr, dm_wdata, e_dm_rd, e_dm_wr, e_dm_addr, e_dm_wdata); else passes++;
            if (e_cpu_srv && !r_wr) begin
                checks++; if (cpu_rdata !== ref_mem[r_ca]) $display("FAIL rnd%0d.cpu_rdata: got %h want %h", n, cpu_rdata, ref_mem[r_ca]); else passes++;
            end
            advance();
            checks++; if (dma_rvalid !== exp_rvalid) $display("FAIL rnd%0d.rvalid: got %0b want %0b", n, dma_rvalid, exp_rvalid); else passes++;
            if (exp_rvalid) begin
                checks++; if (dma_rdata !== exp_rdata) $display("FAIL rnd%0d.rdata: got %h want %h", n, dma_rdata, exp_rdata); else passes++;
            end
            hold_cpu = e_stall;
            dma_pend = r_req && !e_dma_gnt;
        end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_reset_in_force();
        test_dma_rw();
        test_cpu_priority();
        test_starvation();
        test_force_drop();
        test_rw_both();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
